// File: rtl/period_meter.sv
// period_meter: measures the period and high-phase length of a slow, asynchronous
// input in sysclk cycles. Completed periods are published into a held result
// register with a valid/acknowledge handshake, a sticky overrun flag and a stall flag.
module period_meter #(
  parameter int CNT_W   = 26,
  parameter int TIMEOUT = 50000000
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             rd_ack,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             overrun,
  output logic             stalled
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_STALL   = 2'd2;

  // Last counter value before declaring a stall; TIMEOUT < 2^CNT_W keeps
  // the counter and counter+1 inside CNT_W bits.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Synchronizer and edge-history flops
  logic sync1_q;
  logic sync2_q;
  logic hist_q;

  // Measurement state
  logic [1:0]       state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [CNT_W-1:0] hi_cap_q,    hi_cap_d;

  // Published results and flags
  logic [CNT_W-1:0] period_q,    period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             valid_q,     valid_d;
  logic             overrun_q,   overrun_d;
  logic             stalled_q,   stalled_d;

  // Edge strobes and helpers
  logic             rise_s;
  logic             fall_s;
  logic             period_done_s;
  logic [CNT_W-1:0] cnt_plus1_s;

  // Bring sig_in into the sysclk domain and keep one cycle of history.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  // Edge detection on the synchronized signal.
  always_comb begin
    rise_s        = sync2_q & ~hist_q;
    fall_s        = ~sync2_q & hist_q;
    cnt_plus1_s   = cnt_q + CNT_ONE;
    period_done_s = (state_q == ST_MEASURE) && rise_s;
  end

  // Measurement FSM: counter, high-phase capture and stall detection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_cap_d  = hi_cap_q;
    stalled_d = stalled_q;
    case (state_q)
      ST_IDLE: begin
        // Counter stays at zero until the first rise starts a measurement.
        cnt_d = CNT_ZERO;
        if (rise_s) begin
          state_d = ST_MEASURE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MEASURE: begin
        if (rise_s) begin
          // Period boundary: restart counting for the next period.
          cnt_d   = CNT_ZERO;
          state_d = ST_MEASURE;
        end else if (cnt_q == CNT_LAST) begin
          // No rise for TIMEOUT cycles: freeze the counter and flag a stall.
          cnt_d     = cnt_q;
          state_d   = ST_STALL;
          stalled_d = 1'b1;
        end else begin
          cnt_d   = cnt_plus1_s;
          state_d = ST_MEASURE;
        end
        // A fall closes the high phase of the current period.
        if (fall_s) begin
          hi_cap_d = cnt_plus1_s;
        end else begin
          hi_cap_d = hi_cap_q;
        end
      end
      ST_STALL: begin
        if (rise_s) begin
          // Resume measuring; the stalled partial period is discarded.
          cnt_d     = CNT_ZERO;
          state_d   = ST_MEASURE;
          stalled_d = 1'b0;
        end else begin
          cnt_d     = cnt_q;
          state_d   = ST_STALL;
          stalled_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_d     = CNT_ZERO;
        stalled_d = 1'b0;
      end
    endcase
  end

  // Result publication with valid/acknowledge handshake and overrun flag.
  always_comb begin
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    if (period_done_s) begin
      if (!valid_q || rd_ack) begin
        // Slot free, or being freed this very cycle: publish the new period.
        period_d    = cnt_plus1_s;
        high_time_d = hi_cap_q;
        valid_d     = 1'b1;
      end else begin
        // Consumer has not taken the previous result: drop this one.
        overrun_d = 1'b1;
      end
    end else if (valid_q && rd_ack) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_ZERO;
      hi_cap_q    <= CNT_ZERO;
      period_q    <= CNT_ZERO;
      high_time_q <= CNT_ZERO;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      stalled_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_cap_q    <= hi_cap_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      stalled_q   <= stalled_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_time_q;
  assign valid     = valid_q;
  assign overrun   = overrun_q;
  assign stalled   = stalled_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed testbench for period_meter (TIMEOUT reduced to 100 cycles).
// Inputs change and outputs are sampled on the falling edge of sysclk.
module tb_period_meter;

  localparam int CNT_W = 26;

  logic             sysclk;
  logic             reset;
  logic             sig_in;
  logic             rd_ack;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             overrun;
  logic             stalled;

  int tests_run;
  int tests_failed;

  period_meter #(.CNT_W(CNT_W), .TIMEOUT(100)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .sig_in    (sig_in),
    .rd_ack    (rd_ack),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .overrun   (overrun),
    .stalled   (stalled)
  );

  // Free-running clock
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic step(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_period"},    32'(period),    32'd0);
    chk({tag, "_high_time"}, 32'(high_time), 32'd0);
    chk({tag, "_valid"},     32'(valid),     32'd0);
    chk({tag, "_overrun"},   32'(overrun),   32'd0);
    chk({tag, "_stalled"},   32'(stalled),   32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  // Directed sequence. A sig_in change made at a falling edge is acted on
  // by the DUT at the third following rising edge.
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset  = 1'b1;
    sig_in = 1'b0;
    rd_ack = 1'b0;
    step(3);
    chk_all_zero("reset");
    reset = 1'b0;
    step(2);

    // Square wave 4 high / 4 low, acknowledging every result.
    for (int p = 0; p < 4; p++) begin
      sig_in = 1'b1;
      step(3);
      if (p == 0) begin
        chk("sq_first_rise_valid", 32'(valid), 32'd0);
      end else begin
        chk("sq_valid",     32'(valid),     32'd1);
        chk("sq_period",    32'(period),    32'd8);
        chk("sq_high_time", 32'(high_time), 32'd4);
        rd_ack = 1'b1;
      end
      step(1);
      rd_ack = 1'b0;
      sig_in = 1'b0;
      chk("sq_valid_after_ack", 32'(valid),   32'd0);
      chk("sq_overrun",         32'(overrun), 32'd0);
      step(4);
    end

    // Stall: one rise, then low until the timeout expires.
    do_reset();
    step(2);
    sig_in = 1'b1;
    step(4);
    sig_in = 1'b0;
    step(98);
    chk("stall_before", 32'(stalled), 32'd0);
    step(1);
    chk("stall_at",       32'(stalled), 32'd1);
    chk("stall_no_valid", 32'(valid),   32'd0);
    step(5);
    sig_in = 1'b1;
    step(3);
    chk("stall_cleared",        32'(stalled), 32'd0);
    chk("stall_partial_no_pub", 32'(valid),   32'd0);
    sig_in = 1'b0;
    step(7);
    sig_in = 1'b1;
    step(3);
    chk("stall_resume_valid",  32'(valid),     32'd1);
    chk("stall_resume_period", 32'(period),    32'd10);
    chk("stall_resume_high",   32'(high_time), 32'd3);
    chk("stall_resume_flag",   32'(stalled),   32'd0);

    // No acknowledge: three periods of 10 (high 3), then a 14 (high 5) that is also dropped.
    sig_in = 1'b0;
    do_reset();
    step(2);
    for (int p = 0; p < 5; p++) begin
      sig_in = 1'b1;
      step(3);
      if (p >= 1) begin
        chk("ovr_valid",     32'(valid),     32'd1);
        chk("ovr_period",    32'(period),    32'd10);
        chk("ovr_high_time", 32'(high_time), 32'd3);
        chk("ovr_overrun",   32'(overrun),   (p >= 2) ? 32'd1 : 32'd0);
      end
      step((p == 3) ? 2 : 0);
      sig_in = 1'b0;
      step((p == 3) ? 9 : 7);
    end

    // Acknowledge coinciding with a new completion: 10 (high 3) then 12 (high 4).
    do_reset();
    step(2);
    sig_in = 1'b1;
    step(3);
    sig_in = 1'b0;
    step(7);
    sig_in = 1'b1;
    step(3);
    chk("same_first_valid",  32'(valid),     32'd1);
    chk("same_first_period", 32'(period),    32'd10);
    chk("same_first_high",   32'(high_time), 32'd3);
    step(1);
    sig_in = 1'b0;
    step(8);
    sig_in = 1'b1;
    step(2);
    rd_ack = 1'b1;
    step(1);
    rd_ack = 1'b0;
    chk("same_valid",   32'(valid),     32'd1);
    chk("same_period",  32'(period),    32'd12);
    chk("same_high",    32'(high_time), 32'd4);
    chk("same_overrun", 32'(overrun),   32'd0);
    step(1);
    chk("same_valid_held", 32'(valid), 32'd1);
    rd_ack = 1'b1;
    step(1);
    rd_ack = 1'b0;
    chk("ack_valid_clr",   32'(valid),  32'd0);
    chk("ack_period_hold", 32'(period), 32'd12);
    rd_ack = 1'b1;
    step(1);
    rd_ack = 1'b0;
    chk("ack_idle_valid",  32'(valid),     32'd0);
    chk("ack_idle_period", 32'(period),    32'd12);
    chk("ack_idle_high",   32'(high_time), 32'd4);

    // Reset in the middle of a 20-cycle period (high 10).
    sig_in = 1'b0;
    do_reset();
    step(2);
    sig_in = 1'b1;
    step(10);
    sig_in = 1'b0;
    step(10);
    sig_in = 1'b1;
    step(3);
    chk("mid_pre_valid",  32'(valid),  32'd1);
    chk("mid_pre_period", 32'(period), 32'd20);
    step(7);
    sig_in = 1'b0;
    step(5);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk_all_zero("mid_reset");
    step(4);
    sig_in = 1'b1;
    step(3);
    chk("mid_first_rise_valid", 32'(valid), 32'd0);
    step(7);
    sig_in = 1'b0;
    step(10);
    sig_in = 1'b1;
    step(3);
    chk("mid_second_valid",  32'(valid),     32'd1);
    chk("mid_second_period", 32'(period),    32'd20);
    chk("mid_second_high",   32'(high_time), 32'd10);

    // sig_in already high when reset releases; then period 6 (high 3).
    sig_in = 1'b1;
    do_reset();
    step(3);
    sig_in = 1'b0;
    step(3);
    sig_in = 1'b1;
    step(2);
    chk("relhi_before_valid", 32'(valid), 32'd0);
    step(1);
    chk("relhi_valid",  32'(valid),     32'd1);
    chk("relhi_period", 32'(period),    32'd6);
    chk("relhi_high",   32'(high_time), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
